demux_rr_dispatch_v: RTL and testbench

//   Round-robin dispatcher that sequences the 1:4 demux datapath.
//   - Accepts one valid/ready input word stream and routes it in bursts of BURST_LEN words
//     to one of four destination channels.
//   - Arbitrates among destinations that are ready, holds the select code for a whole burst,
//     and drives the demux select, per-channel valid and shared data.

---
 rtl/demux_rr_dispatch_v.sv | 127 ++++++++++++
 tb/tb_demux_rr_dispatch_v.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_dispatch_v.sv
// Round-robin burst dispatcher for a 1:4 demux: arbitrates among ready destinations,
// holds the select for BURST_LEN words, then hands the slot to the next destination.
module demux_rr_dispatch_v #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic [3:0]        i_dst_ready,
  output logic [1:0]        o_sel_code,
  output logic [3:0]        o_dst_valid,
  output logic [DATA_W-1:0] o_dst_data,
  output logic              o_busy,
  output logic              o_burst_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] count_q, count_d;
  logic       done_q, done_d;

  logic       in_burst_s;
  logic       xfer_s;
  logic [2:0] grant_s;

  // Returns {any_request, index}; search starts just after ptr and wraps back to ptr.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    dbl = {req, req};
    rot = 4'(dbl >> (3'(ptr) + 3'd1));
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return {|req, ptr + 2'd1 + off};
  endfunction

  assign in_burst_s = (state_q == ST_BURST);
  assign xfer_s     = in_burst_s & i_valid & i_dst_ready[sel_q];
  assign grant_s    = rr_pick(ptr_q, i_dst_ready);

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && grant_s[2]) begin
          sel_d   = grant_s[1:0];
          count_d = 8'd0;
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (xfer_s) begin
          count_d = count_q + 8'd1;
          if (count_q == LAST_IDX) begin
            state_d = ST_IDLE;
            ptr_d   = sel_q;
            done_d  = 1'b1;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; ptr resets to 3 so the first grant after reset favours destination 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      count_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Handshake outputs follow the live destination ready and source valid.
  always_comb begin
    o_dst_valid = 4'b0000;
    o_ready     = 1'b0;
    if (in_burst_s) begin
      o_ready     = i_dst_ready[sel_q];
      o_dst_valid = 4'({3'b000, i_valid}) << sel_q;
    end else begin
      o_ready     = 1'b0;
      o_dst_valid = 4'b0000;
    end
  end

  assign o_sel_code   = sel_q;
  assign o_dst_data   = i_data;
  assign o_busy       = in_burst_s;
  assign o_burst_done = done_q;

endmodule

// File: tb/tb_demux_rr_dispatch_v.sv
// Directed bench for demux_rr_dispatch_v: a burst-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_demux_rr_dispatch_v;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic [3:0]        i_dst_ready;
  logic [1:0]        o_sel_code;
  logic [3:0]        o_dst_valid;
  logic [DATA_W-1:0] o_dst_data;
  logic              o_busy;
  logic              o_burst_done;

  demux_rr_dispatch_v #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .i_dst_ready  (i_dst_ready),
    .o_sel_code   (o_sel_code),
    .o_dst_valid  (o_dst_valid),
    .o_dst_data   (o_dst_data),
    .o_busy       (o_busy),
    .o_burst_done (o_burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whether a burst is open, its destination, words still owed,
  // the destination served last, and the done pulse.
  logic       m_busy;
  logic [1:0] m_ch;
  int         m_left;
  int         m_last;
  logic       m_done;
  logic [3:0] exp_valid;

  function automatic logic [1:0] next_grant(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return 2'((last + k) % 4);
    end
    return 2'(last);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ch   <= 2'd0;
      m_left <= 0;
      m_last <= 3;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (i_valid && i_dst_ready != 4'b0000) begin
          m_ch   <= next_grant(m_last, i_dst_ready);
          m_busy <= 1'b1;
          m_left <= BURST_LEN;
        end
      end else if (i_valid && i_dst_ready[m_ch]) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_last <= int'(m_ch);
          m_done <= 1'b1;
        end
        m_left <= m_left - 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    exp_valid = (m_busy && i_valid) ? (4'b0001 << m_ch) : 4'b0000;
    check("mdl_busy",  32'(o_busy),       32'(m_busy));
    check("mdl_sel",   32'(o_sel_code),   32'(m_ch));
    check("mdl_ready", 32'(o_ready),      32'(m_busy && i_dst_ready[m_ch]));
    check("mdl_valid", 32'(o_dst_valid),  32'(exp_valid));
    check("mdl_done",  32'(o_burst_done), 32'(m_done));
    check("mdl_data",  32'(o_dst_data),   32'(i_data));
  end

  // Finishes a cycle started at the falling edge; a handshake advances the source data.
  task automatic end_cycle();
    logic hs;
    hs = i_valid && o_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      i_data = i_data + 8'd1;
      n_hs++;
    end
  endtask

  task automatic finish_burst(input string name);
    logic seen;
    seen = 1'b0;
    i_valid     = 1'b1;
    i_dst_ready = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      end_cycle();
      if (o_burst_done) begin
        i_valid = 1'b0;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  logic [1:0] grants [4];
  int         ng;
  logic       prev_busy;
  int         hs0;
  logic       tog;
  logic       seen5;

  initial begin
    rst_n       = 1'b0;
    i_valid     = 1'b0;
    i_data      = 8'h10;
    i_dst_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel",   32'(o_sel_code),   32'd0);
    check("rst_busy",  32'(o_busy),       32'd0);
    check("rst_ready", 32'(o_ready),      32'd0);
    check("rst_valid", 32'(o_dst_valid),  32'd0);
    check("rst_done",  32'(o_burst_done), 32'd0);

    // Scenario 1: first burst to destination 0 with data 0x10..0x13.
    rst_n       = 1'b1;
    i_valid     = 1'b1;
    i_dst_ready = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) check("t1_arb_busy", 32'(o_busy), 32'd0);
      if (k >= 2 && k <= 5) begin
        check("t1_valid", 32'(o_dst_valid), 32'h1);
        check("t1_data",  32'(o_dst_data),  32'(8'h10 + 8'(k - 2)));
      end
      if (k == 6) check("t1_done", 32'(o_burst_done), 32'd1);
      end_cycle();
    end
    check("t1_next_sel", 32'(o_sel_code), 32'd1);

    // Scenario 2: only destinations 1 and 3 ready, bursts alternate.
    i_dst_ready = 4'b1010;
    ng = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_busy && !prev_busy) begin
        if (ng < 4) grants[ng] = o_sel_code;
        ng++;
      end
      prev_busy = o_busy;
      end_cycle();
    end
    check("t2_nbursts", 32'(ng), 32'd4);
    check("t2_g0", 32'(grants[0]), 32'd1);
    check("t2_g1", 32'(grants[1]), 32'd3);
    check("t2_g2", 32'(grants[2]), 32'd1);
    check("t2_g3", 32'(grants[3]), 32'd3);
    finish_burst("t2_drain_timeout");

    // Scenario 3: destination 2 drops ready mid-burst for three cycles.
    i_valid     = 1'b1;
    i_dst_ready = 4'b0100;
    @(negedge clk);
    end_cycle();
    check("t3_sel", 32'(o_sel_code), 32'd2);
    hs0 = n_hs;
    repeat (2) begin
      @(negedge clk);
      check("t3_ready_pre", 32'(o_ready), 32'd1);
      end_cycle();
    end
    i_dst_ready = 4'b1011;
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_ready", 32'(o_ready),     32'd0);
      check("t3_stall_sel",   32'(o_sel_code),  32'd2);
      check("t3_stall_valid", 32'(o_dst_valid), 32'h4);
      end_cycle();
    end
    i_dst_ready = 4'b0100;
    repeat (2) begin
      @(negedge clk);
      check("t3_ready_post", 32'(o_ready), 32'd1);
      end_cycle();
    end
    check("t3_done",  32'(o_burst_done), 32'd1);
    check("t3_words", 32'(n_hs - hs0),   32'd4);
    i_valid = 1'b0;

    // Scenario 4: nobody ready keeps the dispatcher idle, then destination 2 wins.
    i_valid     = 1'b1;
    i_dst_ready = 4'b0000;
    repeat (10) begin
      @(negedge clk);
      check("t4_busy",  32'(o_busy),      32'd0);
      check("t4_valid", 32'(o_dst_valid), 32'd0);
      end_cycle();
    end
    i_dst_ready = 4'b0100;
    @(negedge clk);
    end_cycle();
    check("t4_sel",  32'(o_sel_code), 32'd2);
    check("t4_busy_after", 32'(o_busy), 32'd1);

    // Scenario 5: source valid toggles; only handshakes advance the burst.
    hs0 = n_hs;
    tog = 1'b1;
    seen5 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i_valid = tog;
      tog = ~tog;
      @(negedge clk);
      check("t5_valid", 32'(o_dst_valid), i_valid ? 32'h4 : 32'h0);
      end_cycle();
      if (o_burst_done) begin
        seen5 = 1'b1;
        break;
      end
    end
    check("t5_done_seen", 32'(seen5), 32'd1);
    check("t5_words", 32'(n_hs - hs0), 32'd4);
    i_valid = 1'b0;

    // Scenario 6: asynchronous reset after two words to destination 1.
    i_valid     = 1'b1;
    i_dst_ready = 4'b0010;
    @(negedge clk);
    end_cycle();
    check("t6_sel", 32'(o_sel_code), 32'd1);
    repeat (2) begin
      @(negedge clk);
      end_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  32'(o_busy),       32'd0);
    check("t6_rst_ready", 32'(o_ready),      32'd0);
    check("t6_rst_valid", 32'(o_dst_valid),  32'd0);
    check("t6_rst_sel",   32'(o_sel_code),   32'd0);
    check("t6_rst_done",  32'(o_burst_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    i_dst_ready = 4'b1111;
    @(negedge clk);
    end_cycle();
    check("t6_regrant_sel",  32'(o_sel_code), 32'd0);
    check("t6_regrant_busy", 32'(o_busy),     32'd1);
    finish_burst("t6_drain_timeout");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
